store_align_buffer: RTL and testbench

- Store-side counterpart to the immediate/load extension path.
- Takes sb/sh/sw requests from the MEM stage and narrows the register data into byte lanes.
- Generates byte write enables and flags misaligned addresses (AdES).
- Queues accepted stores in a small FIFO that drains to the data-memory write port over a req/ack handshake, so the pipeline stalls only when the buffer is full.

---
 rtl/store_align_buffer.sv | 138 +++++++++++++
 tb/tb_store_align_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/store_align_buffer.sv
// -----------------------------------------------------------------------------
// store_align_buffer
//
// Purpose:
//   Store-side lane formatter and write buffer. sb/sh/sw requests from the MEM
//   stage are checked for alignment, narrowed into byte lanes with matching
//   byte enables, and queued in a small FIFO. The FIFO drains to the
//   data-memory write port over a req/ack handshake. Misaligned stores raise
//   an address exception (AdES) and are dropped instead of being queued.
//
// Ports:
//   clk        in   system clock, rising-edge
//   resetn     in   asynchronous active-low reset
//   st_valid   in   MEM stage presents a store
//   st_ready   out  buffer can take the store (MEM stalls when low)
//   st_size    in   00 byte, 01 half, 10 word, 11 reserved
//   st_addr    in   byte address of the store
//   st_data    in   rt register value
//   ades       out  store address exception, same cycle as the accept
//   badvaddr   out  faulting address while ades=1, else 0
//   mem_req    out  head entry valid
//   mem_addr   out  word-aligned head address
//   mem_wdata  out  lane-replicated head write data
//   mem_wen    out  head byte write enables
//   mem_ack    in   memory consumed the head entry
//   sb_empty   out  no stores pending
// -----------------------------------------------------------------------------
module store_align_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [1:0]    st_size,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    output logic          ades,
    output logic [AW-1:0] badvaddr,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wen,
    input  logic          mem_ack,
    output logic          sb_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Reserved size encoding is treated as misaligned so it never reaches memory.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lo[0];
            2'b10:   misaligned = (lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   lane_data = {4{data[7:0]}};
            2'b01:   lane_data = {2{data[15:0]}};
            2'b10:   lane_data = data;
            default: lane_data = 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] lane_wen(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   lane_wen = 4'b0001 << lo;
            2'b01:   lane_wen = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_wen = 4'b1111;
            default: lane_wen = 4'b0000;
        endcase
    endfunction

    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Entry storage carries data only; validity is tracked by count, so it
    // needs no reset.
    logic [AW-1:0] addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    wen_mem  [DEPTH];

    logic mis;
    logic fire;
    logic enq;
    logic deq;

    assign mis      = misaligned(st_size, st_addr[1:0]);
    assign mem_req  = (count != '0);
    assign deq      = mem_req && mem_ack;
    // A full buffer still accepts when the head is leaving this same cycle.
    assign st_ready = (count < FULL) || deq;
    assign fire     = st_valid && st_ready;
    assign enq      = fire && !mis;

    assign ades     = fire && mis;
    assign badvaddr = ades ? st_addr : '0;

    assign sb_empty  = (count == '0);
    assign mem_addr  = mem_req ? addr_mem[rd_ptr] : '0;
    assign mem_wdata = mem_req ? data_mem[rd_ptr] : '0;
    assign mem_wen   = mem_req ? wen_mem[rd_ptr]  : '0;

    // Enqueue stage: formatted store is written into the tail slot
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr] <= {st_addr[AW-1:2], 2'b00};
            data_mem[wr_ptr] <= lane_data(st_size, st_data);
            wen_mem[wr_ptr]  <= lane_wen(st_size, st_addr[1:0]);
        end
    end

    // Occupancy and pointers; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_align_buffer.sv
module tb_store_align_buffer;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          st_valid;
    logic          st_ready;
    logic [1:0]    st_size;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          ades;
    logic [AW-1:0] badvaddr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wen;
    logic          mem_ack;
    logic          sb_empty;

    store_align_buffer #(.DEPTH(2), .AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
        .ades(ades), .badvaddr(badvaddr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_ack(mem_ack), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    // Monitor: every accepted head entry is compared against the scoreboard.
    always @(negedge clk) begin
        if (resetn && mem_req && mem_ack) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("drain_addr", mem_addr, e.a);
                chk("drain_wdata", mem_wdata, e.d);
                chk("drain_wen", {28'h0, mem_wen}, {28'h0, e.w});
            end
        end
    end

    // One stimulus cycle: drive, check handshake/exception at the negedge,
    // push expected entry if it is accepted, then move past the next posedge.
    task automatic cyc(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                       input logic rdy, input logic ad,
                       input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] ew);
        exp_t e;
        st_valid = 1'b1; st_size = size; st_addr = addr; st_data = data;
        @(negedge clk);
        chk("st_ready", {31'h0, st_ready}, {31'h0, rdy});
        chk("ades", {31'h0, ades}, {31'h0, ad});
        chk("badvaddr", badvaddr, ad ? addr : 32'h0);
        if (rdy && !ad) begin
            e.a = ea; e.d = ed; e.w = ew;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        st_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; st_valid = 1'b0; st_size = 2'b00; st_addr = '0; st_data = '0; mem_ack = 1'b0;
        #2;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wen", {28'h0, mem_wen}, 32'h0);
        chk("rst_sb_empty", {31'h0, sb_empty}, 32'h1);
        chk("rst_ades", {31'h0, ades}, 32'h0);
        chk("rst_badvaddr", badvaddr, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        mem_ack = 1'b1;  // ack while empty must be ignored
        idle(2);
        chk("empty_after_idle_ack", {31'h0, sb_empty}, 32'h1);

        // sb 0x1003: not visible before the accepting edge, visible one cycle after
        st_valid = 1'b1; st_size = 2'b00; st_addr = 32'h1003; st_data = 32'h1234_56AB;
        @(negedge clk);
        chk("sb_ready", {31'h0, st_ready}, 32'h1);
        chk("sb_no_comb_req", {31'h0, mem_req}, 32'h0);
        sb_q.push_back('{a: 32'h1000, d: 32'hABAB_ABAB, w: 4'b1000});
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("sb_req_next", {31'h0, mem_req}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sb_empty_after_ack", {31'h0, sb_empty}, 32'h1);
        chk("idle_addr_zero", mem_addr, 32'h0);
        @(posedge clk); #1;

        // Halfword / word / byte lane formatting
        cyc(2'b01, 32'h2002, 32'hDEAD_BEEF, 1, 0, 32'h2000, 32'hBEEF_BEEF, 4'b1100);
        cyc(2'b10, 32'h2004, 32'hCAFE_F00D, 1, 0, 32'h2004, 32'hCAFE_F00D, 4'b1111);
        cyc(2'b01, 32'h2008, 32'h0000_5A5A, 1, 0, 32'h2008, 32'h5A5A_5A5A, 4'b0011);
        cyc(2'b00, 32'h2009, 32'hFFFF_FF3C, 1, 0, 32'h2008, 32'h3C3C_3C3C, 4'b0010);
        idle(2);

        // Misaligned stores: exception, nothing enqueued
        cyc(2'b01, 32'h3001, 32'h1111_1111, 1, 1, 0, 0, 0);
        cyc(2'b10, 32'h3002, 32'h2222_2222, 1, 1, 0, 0, 0);
        cyc(2'b11, 32'h3000, 32'h3333_3333, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("mis_empty", {31'h0, sb_empty}, 32'h1);
        chk("mis_no_req", {31'h0, mem_req}, 32'h0);
        @(posedge clk); #1;

        // Backpressure: fill with ack low, then same-cycle enqueue/dequeue
        mem_ack = 1'b0;
        cyc(2'b10, 32'h4000, 32'hA0A0_A0A0, 1, 0, 32'h4000, 32'hA0A0_A0A0, 4'b1111);
        cyc(2'b10, 32'h4004, 32'hA1A1_A1A1, 1, 0, 32'h4004, 32'hA1A1_A1A1, 4'b1111);
        cyc(2'b10, 32'h4008, 32'hA2A2_A2A2, 0, 0, 0, 0, 0);
        chk("stall_head_addr", mem_addr, 32'h4000);
        cyc(2'b01, 32'h4009, 32'hA2A2_A2A2, 0, 0, 0, 0, 0);  // misaligned while full: no ades
        chk("stall_head_data", mem_wdata, 32'hA0A0_A0A0);
        mem_ack = 1'b1;
        cyc(2'b10, 32'h4008, 32'hA2A2_A2A2, 1, 0, 32'h4008, 32'hA2A2_A2A2, 4'b1111);
        idle(4);
        chk("full_drained", {31'h0, sb_empty}, 32'h1);

        // Streaming with ack every cycle: one store per cycle, pointer wrap
        for (int i = 0; i < 6; i++) begin
            cyc(2'b10, 32'h5000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 1, 0,
                32'h5000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'b1111);
        end
        idle(3);
        chk("stream_empty", {31'h0, sb_empty}, 32'h1);
        chk("stream_q_drained", 32'(sb_q.size()), 32'h0);

        // Asynchronous reset mid-drain discards pending entries
        mem_ack = 1'b0;
        cyc(2'b10, 32'h6000, 32'h6060_6060, 1, 0, 32'h6000, 32'h6060_6060, 4'b1111);
        cyc(2'b10, 32'h6004, 32'h6161_6161, 1, 0, 32'h6004, 32'h6161_6161, 4'b1111);
        @(negedge clk);
        chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_req", {31'h0, mem_req}, 32'h0);
        chk("async_rst_empty", {31'h0, sb_empty}, 32'h1);
        chk("async_rst_addr", mem_addr, 32'h0);
        sb_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_req", {31'h0, mem_req}, 32'h0);
        end
        @(posedge clk); #1;

        chk("final_q_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
